fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register; feeds the decode stage with

---
 rtl/fetch_stage_pkg.sv | 16 +
 rtl/fetch_stage_ifid_reg.sv | 55 +++++
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/control constants: bubble and HALT encodings, FSM states, reset PC.
package fetch_stage_pkg;

   localparam logic [15:0] RESET_PC_DEF  = 16'h0000;
   localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;  // opcode 5'b00001
   localparam logic [15:0] PC_STEP_DEF   = 16'd2;
   localparam logic [4:0]  OPC_NOP       = 5'b00001;
   localparam logic [4:0]  OPC_HALT      = 5'b00000;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_WAIT_MEM = 2'd1,
      ST_HALTED   = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: instruction, PC+2 and valid bit with hold and flush.
// Flush beats hold; with neither asserted the fetched word is captured as valid.
module fetch_stage_ifid_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hold_i,
   input  logic        flush_i,
   input  logic [15:0] instr_i,
   input  logic [15:0] pc_plus2_i,
   output logic [15:0] instr_o,
   output logic [15:0] pc_plus2_o,
   output logic        valid_o
);

   logic [15:0] instr_q, instr_d;
   logic [15:0] pc_plus2_q, pc_plus2_d;
   logic        valid_q, valid_d;

   // Select bubble, hold or capture for the IF/ID slot.
   always_comb begin
      instr_d    = instr_q;
      pc_plus2_d = pc_plus2_q;
      valid_d    = valid_q;
      if (flush_i) begin
         instr_d = NOP_INSTR;
         valid_d = 1'b0;
      end else if (!hold_i) begin
         instr_d    = instr_i;
         pc_plus2_d = pc_plus2_i;
         valid_d    = 1'b1;
      end
   end

   // Slot registers, cleared to a bubble on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q    <= NOP_INSTR;
         pc_plus2_q <= 16'h0000;
         valid_q    <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         pc_plus2_q <= pc_plus2_d;
         valid_q    <= valid_d;
      end
   end

   assign instr_o    = instr_q;
   assign pc_plus2_o = pc_plus2_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC and fetch FSM, drives imem, feeds IF/ID.
// Per-edge priority: reset, redirect, halt, stall, memory ready.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = RESET_PC_DEF,
   parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF,
   parameter logic [15:0] PC_STEP   = PC_STEP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] Imem_addr,
   input  logic [15:0] Imem_data,
   input  logic        Imem_ready,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [15:0] Redirect_target,
   input  logic        Halt_decoded,
   output logic [15:0] Instruction,
   output logic [15:0] Pc_plus2,
   output logic        Valid_PC,
   output logic        Halted,
   output logic        err
);

   fetch_state_e state_q, state_d;
   logic [15:0]  pc_q, pc_d;
   logic         halted_q, halted_d;
   logic         err_q, err_d;
   logic         ifid_hold, ifid_flush;
   logic [15:0]  pc_next;

   // 16-bit wrap; carry out is intentionally dropped.
   assign pc_next = pc_q + PC_STEP;

   // Next-state, PC and IF/ID control decode.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      halted_d   = halted_q;
      err_d      = err_q;
      ifid_hold  = 1'b0;
      ifid_flush = 1'b0;
      if (state_q == ST_HALTED) begin
         // Frozen until reset; redirects are ignored here.
         ifid_flush = 1'b1;
      end else if (Redirect) begin
         pc_d       = {Redirect_target[15:1], 1'b0};
         err_d      = err_q | Redirect_target[0];
         ifid_flush = 1'b1;
         state_d    = ST_RUN;
      end else if (Halt_decoded) begin
         state_d    = ST_HALTED;
         halted_d   = 1'b1;
         ifid_flush = 1'b1;
      end else if (Stall) begin
         // In WAIT_MEM the slot already holds a bubble, so holding keeps it.
         ifid_hold = 1'b1;
      end else if (Imem_ready) begin
         pc_d    = pc_next;
         state_d = ST_RUN;
      end else begin
         ifid_flush = 1'b1;
         state_d    = ST_WAIT_MEM;
      end
   end

   // Fetch FSM, PC and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_RUN;
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
         err_q    <= err_d;
      end
   end

   fetch_stage_ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid (
      .clk        (clk),
      .rst        (rst),
      .hold_i     (ifid_hold),
      .flush_i    (ifid_flush),
      .instr_i    (Imem_data),
      .pc_plus2_i (pc_next),
      .instr_o    (Instruction),
      .pc_plus2_o (Pc_plus2),
      .valid_o    (Valid_PC)
   );

   assign Imem_addr = pc_q;
   assign Halted    = halted_q;
   assign err       = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, redirect, memory wait,
// halt, odd redirect target and PC wrap.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] Imem_addr;
   logic [15:0] Imem_data;
   logic        Imem_ready;
   logic        Stall;
   logic        Redirect;
   logic [15:0] Redirect_target;
   logic        Halt_decoded;
   logic [15:0] Instruction;
   logic [15:0] Pc_plus2;
   logic        Valid_PC;
   logic        Halted;
   logic        err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Memory image: two fixed words at 0 and 2, otherwise 16'h7000 + address.
   always_comb begin
      if (Imem_addr == 16'h0000)      Imem_data = 16'h4001;
      else if (Imem_addr == 16'h0002) Imem_data = 16'h4002;
      else                            Imem_data = 16'h7000 + Imem_addr;
   end

   fetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .Imem_addr       (Imem_addr),
      .Imem_data       (Imem_data),
      .Imem_ready      (Imem_ready),
      .Stall           (Stall),
      .Redirect        (Redirect),
      .Redirect_target (Redirect_target),
      .Halt_decoded    (Halt_decoded),
      .Instruction     (Instruction),
      .Pc_plus2        (Pc_plus2),
      .Valid_PC        (Valid_PC),
      .Halted          (Halted),
      .err             (err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; Imem_ready = 1'b1; Stall = 1'b0; Redirect = 1'b0;
      Redirect_target = 16'h0000; Halt_decoded = 1'b0;
      #2;
      step();
      chk("rst_addr",   Imem_addr,   16'h0000);
      chk("rst_instr",  Instruction, 16'h0800);
      chk("rst_valid",  {15'd0, Valid_PC}, 16'd0);
      chk("rst_pc2",    Pc_plus2,    16'h0000);
      chk("rst_halted", {15'd0, Halted}, 16'd0);
      chk("rst_err",    {15'd0, err},    16'd0);
      rst = 1'b0;

      // 1: sequential fetch
      step();
      chk("t1_instr0", Instruction, 16'h4001);
      chk("t1_valid0", {15'd0, Valid_PC}, 16'd1);
      chk("t1_pc2_0",  Pc_plus2,    16'h0002);
      chk("t1_addr2",  Imem_addr,   16'h0002);
      step();
      chk("t1_instr1", Instruction, 16'h4002);
      chk("t1_pc2_1",  Pc_plus2,    16'h0004);
      chk("t1_addr4",  Imem_addr,   16'h0004);

      // 2: stall holds PC and IF/ID
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_addr",  Imem_addr,   16'h0004);
         chk("t2_instr", Instruction, 16'h4002);
         chk("t2_valid", {15'd0, Valid_PC}, 16'd1);
      end
      Stall = 1'b0;
      step();
      chk("t2_res_instr", Instruction, 16'h7004);
      chk("t2_res_addr",  Imem_addr,   16'h0006);
      chk("t2_res_pc2",   Pc_plus2,    16'h0006);

      // 3: redirect wins over simultaneous stall
      Stall = 1'b1; Redirect = 1'b1; Redirect_target = 16'h0040;
      step();
      chk("t3_addr",  Imem_addr,   16'h0040);
      chk("t3_valid", {15'd0, Valid_PC}, 16'd0);
      chk("t3_instr", Instruction, 16'h0800);
      Stall = 1'b0; Redirect = 1'b0;
      step();
      chk("t3_tgt_instr", Instruction, 16'h7040);
      chk("t3_tgt_valid", {15'd0, Valid_PC}, 16'd1);
      chk("t3_tgt_pc2",   Pc_plus2,    16'h0042);

      // 4: memory not ready at PC=8
      Redirect = 1'b1; Redirect_target = 16'h0008;
      step();
      chk("t4_addr8", Imem_addr, 16'h0008);
      Redirect = 1'b0; Imem_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("t4_bub_valid", {15'd0, Valid_PC}, 16'd0);
         chk("t4_bub_instr", Instruction, 16'h0800);
         chk("t4_bub_addr",  Imem_addr,   16'h0008);
      end
      Imem_ready = 1'b1;
      step();
      chk("t4_cap_instr", Instruction, 16'h7008);
      chk("t4_cap_pc2",   Pc_plus2,    16'h000A);
      chk("t4_cap_valid", {15'd0, Valid_PC}, 16'd1);
      chk("t4_cap_addr",  Imem_addr,   16'h000A);

      // 5: halt freezes fetch; redirect ignored; reset clears
      Halt_decoded = 1'b1;
      step();
      chk("t5_halted", {15'd0, Halted}, 16'd1);
      chk("t5_valid",  {15'd0, Valid_PC}, 16'd0);
      chk("t5_addr",   Imem_addr, 16'h000A);
      Halt_decoded = 1'b0;
      step();
      chk("t5_addr_hold", Imem_addr, 16'h000A);
      Redirect = 1'b1; Redirect_target = 16'h0100;
      step();
      chk("t5_redir_ign", Imem_addr, 16'h000A);
      chk("t5_still_hlt", {15'd0, Halted}, 16'd1);
      Redirect = 1'b0; rst = 1'b1;
      step();
      chk("t5_rst_halted", {15'd0, Halted}, 16'd0);
      chk("t5_rst_addr",   Imem_addr, 16'h0000);
      rst = 1'b0;

      // 6: odd redirect target and PC wrap
      Redirect = 1'b1; Redirect_target = 16'h0013;
      step();
      chk("t6_err",  {15'd0, err}, 16'd1);
      chk("t6_addr", Imem_addr, 16'h0012);
      Redirect = 1'b0;
      step();
      chk("t6_err_sticky", {15'd0, err}, 16'd1);
      chk("t6_instr",      Instruction, 16'h7012);
      chk("t6_addr14",     Imem_addr,   16'h0014);
      Redirect = 1'b1; Redirect_target = 16'hFFFE;
      step();
      chk("t6_addr_fffe", Imem_addr, 16'hFFFE);
      Redirect = 1'b0;
      step();
      chk("t6_wrap_addr",  Imem_addr,   16'h0000);
      chk("t6_wrap_pc2",   Pc_plus2,    16'h0000);
      chk("t6_wrap_instr", Instruction, 16'h6FFE);
      chk("t6_err_keep",   {15'd0, err}, 16'd1);
      rst = 1'b1;
      step();
      chk("t6_rst_err", {15'd0, err}, 16'd0);
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
